glitc_phase_shift_ctrl: RTL and testbench

Sequencer for the sysclk MMCM dynamic phase shifter in the GLITC clock generator. It accepts relative move and return-to-zero commands, then emits single-cycle PSEN/PSINCDEC pulses one at a time, waiting for PSDONE after each. It tracks the signed phase-step position, detects lock loss and PSDONE timeouts, and exposes busy, done and error status to the register interface.

---
 rtl/glitc_phase_shift_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_glitc_phase_shift_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_phase_shift_ctrl.sv
// Sequencer for the sysclk MMCM dynamic phase shifter. Accepts relative move
// and return-to-zero commands and issues one PSEN pulse at a time, waiting for
// PSDONE after each. It tracks the signed step position and flags lock loss or
// PSDONE timeouts.
module glitc_phase_shift_ctrl #(
  parameter int PHASE_WIDTH  = 16,
  parameter int DONE_TIMEOUT = 63
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_zero_i,
  input  logic                   req_dir_i,
  input  logic [PHASE_WIDTH-1:0] req_steps_i,
  input  logic                   mmcm_rst_i,
  input  logic                   locked_i,
  output logic                   ps_en_o,
  output logic                   ps_incdec_o,
  input  logic                   ps_done_i,
  output logic [PHASE_WIDTH-1:0] position_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  input  logic                   err_clr_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT,
    ST_GAP,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LOCK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // The wait counter is 0 in the first WAIT cycle, so it reaches this value in
  // the last cycle where PSDONE is still allowed to arrive.
  localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT - 1);
  localparam logic [PHASE_WIDTH-1:0] STEP_ONE = {{(PHASE_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] remaining_q, remaining_d;
  logic                   dir_q, dir_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [PHASE_WIDTH-1:0] position_d;
  logic                   err_d;
  logic [1:0]             err_code_d;
  logic                   done_d;
  logic                   ps_en_d;
  logic                   ps_incdec_d;
  logic                   busy_d;

  logic                   locked_meta;
  logic                   locked_s;

  logic                   accept;
  logic                   pos_neg;
  logic [PHASE_WIDTH-1:0] pos_mag;
  logic [PHASE_WIDTH-1:0] cmd_steps;
  logic                   cmd_dir;

  assign req_ready_o = (state_q == ST_IDLE) && !mmcm_rst_i;
  assign accept      = req_valid_i && req_ready_o;

  // Magnitude is unsigned so the most-negative position yields 2^(W-1).
  assign pos_neg   = position_o[PHASE_WIDTH-1];
  assign pos_mag   = pos_neg ? (~position_o + STEP_ONE) : position_o;
  assign cmd_steps = req_zero_i ? pos_mag : req_steps_i;
  assign cmd_dir   = req_zero_i ? pos_neg : req_dir_i;

  // Two-flop synchroniser for the asynchronous MMCM LOCKED signal.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked_i;
      locked_s    <= locked_meta;
    end
  end

  // Next-state and next-output logic; mmcm_rst_i overrides everything last.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    wait_cnt_d  = wait_cnt_q;
    position_d  = position_o;
    err_d       = err_o;
    err_code_d  = err_code_o;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (!locked_s) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_LOCK;
          end else begin
            state_d     = ST_PULSE;
            remaining_d = cmd_steps;
            dir_d       = cmd_dir;
          end
        end
      end
      ST_PULSE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (ps_done_i) begin
          position_d  = dir_q ? (position_o + STEP_ONE) : (position_o - STEP_ONE);
          remaining_d = remaining_q - STEP_ONE;
          if (remaining_q == STEP_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (!locked_s) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_LOCK;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_ERR: begin
        if (err_clr_i) begin
          state_d    = ST_IDLE;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (mmcm_rst_i) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      wait_cnt_d  = '0;
      position_d  = '0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      done_d      = 1'b0;
    end

    ps_en_d     = (state_d == ST_PULSE);
    ps_incdec_d = (state_d == ST_PULSE) ? dir_d : ps_incdec_o;
    busy_d      = (state_d == ST_PULSE) || (state_d == ST_WAIT) || (state_d == ST_GAP);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      wait_cnt_q  <= '0;
      position_o  <= '0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      done_o      <= 1'b0;
      ps_en_o     <= 1'b0;
      ps_incdec_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      wait_cnt_q  <= wait_cnt_d;
      position_o  <= position_d;
      err_o       <= err_d;
      err_code_o  <= err_code_d;
      done_o      <= done_d;
      ps_en_o     <= ps_en_d;
      ps_incdec_o <= ps_incdec_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_glitc_phase_shift_ctrl.sv
// Testbench for glitc_phase_shift_ctrl with a 4-bit position so wrap-around is
// reachable. A simple MMCM model answers each PSEN after model_k cycles, and
// every PSEN/done pulse is matched against a queue of expected events.
module tb_glitc_phase_shift_ctrl;

  localparam int PW = 4;
  localparam int TO = 63;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_zero_i;
  logic          req_dir_i;
  logic [PW-1:0] req_steps_i;
  logic          mmcm_rst_i;
  logic          locked_i;
  logic          ps_en_o;
  logic          ps_incdec_o;
  logic          ps_done_i;
  logic [PW-1:0] position_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic          err_clr_i;

  logic model_done  = 1'b0;
  logic manual_done = 1'b0;
  assign ps_done_i = model_done | manual_done;

  glitc_phase_shift_ctrl #(
    .PHASE_WIDTH (PW),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_zero_i (req_zero_i),
    .req_dir_i  (req_dir_i),
    .req_steps_i(req_steps_i),
    .mmcm_rst_i (mmcm_rst_i),
    .locked_i   (locked_i),
    .ps_en_o    (ps_en_o),
    .ps_incdec_o(ps_incdec_o),
    .ps_done_i  (ps_done_i),
    .position_o (position_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .err_clr_i  (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          kind;
    int          cycle;
    logic [31:0] value;
  } ev_t;

  typedef struct {
    bit            zero;
    bit            dir;
    logic [PW-1:0] steps;
    int            k;
    logic [PW-1:0] exp_pos;
  } vec_t;

  ev_t           sb[$];
  vec_t          vecs[11];
  int            cyc = 0;
  int            n_compared = 0;
  int            n_mismatched = 0;
  int            model_k = 12;
  bit            model_respond = 1'b1;
  logic [PW-1:0] model_pos = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic handleEvent(input int kind, input logic [31:0] value);
    ev_t e;
    checkOutput(kind == 0 ? "psen_expected" : "done_expected", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("ev_kind", kind, e.kind);
      checkOutput(kind == 0 ? "psen_cycle" : "done_cycle", cyc, e.cycle);
      checkOutput(kind == 0 ? "psen_incdec" : "done_position", value, e.value);
    end
  endtask

  // Cycle counter and event monitor, sampled just after each rising edge.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    if (rst_n_i === 1'b1) begin
      if (ps_en_o === 1'b1) handleEvent(0, 32'(ps_incdec_o));
      if (done_o === 1'b1) handleEvent(1, 32'(position_o));
    end
  end

  // MMCM model: PSDONE is high in cycle t+model_k for a PSEN in cycle t.
  always begin
    @(negedge clk_i);
    if (ps_en_o === 1'b1 && model_respond) begin
      repeat (model_k) @(negedge clk_i);
      model_done = 1'b1;
      @(negedge clk_i);
      model_done = 1'b0;
    end
  end

  task automatic waitCycle(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit zero, input bit dir, input logic [PW-1:0] steps,
                               input int k, input string name);
    int rem;
    bit d;
    int n;
    @(negedge clk_i);
    model_k = k;
    checkOutput({name, "_ready"}, 32'(req_ready_o), 1);
    if (zero) begin
      d   = model_pos[PW-1];
      rem = d ? ((1 << PW) - int'(model_pos)) : int'(model_pos);
    end else begin
      d   = dir;
      rem = int'(steps);
    end
    req_valid_i = 1'b1;
    req_zero_i  = zero;
    req_dir_i   = dir;
    req_steps_i = steps;
    n = cyc;
    if (rem == 0) begin
      sb.push_back('{1, n + 1, 32'(model_pos)});
    end else begin
      for (int i = 0; i < rem; i++) begin
        sb.push_back('{0, n + 1 + i * (k + 2), 32'(d)});
        model_pos = d ? PW'(model_pos + 1) : PW'(model_pos - 1);
      end
      sb.push_back('{1, n + rem * (k + 2), 32'(model_pos)});
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    if (rem > 0) checkOutput({name, "_busy"}, 32'(busy_o), 1);
    for (int i = 0; i < rem * (k + 2) + 10 && sb.size() != 0; i++) @(negedge clk_i);
    checkOutput({name, "_drained"}, sb.size(), 0);
    sb.delete();
    @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int t2;

    vecs[0]  = '{1'b0, 1'b1, 4'd3,  12, 4'd3};
    vecs[1]  = '{1'b0, 1'b0, 4'd8,  2,  4'hB};
    vecs[2]  = '{1'b1, 1'b0, 4'd7,  3,  4'd0};
    vecs[3]  = '{1'b1, 1'b0, 4'd0,  3,  4'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'd8,  1,  4'h8};
    vecs[5]  = '{1'b0, 1'b0, 4'd1,  5,  4'h7};
    vecs[6]  = '{1'b0, 1'b1, 4'd1,  4,  4'h8};
    vecs[7]  = '{1'b1, 1'b0, 4'd0,  2,  4'd0};
    vecs[8]  = '{1'b0, 1'b1, 4'd0,  3,  4'd0};
    vecs[9]  = '{1'b0, 1'b1, 4'd15, 1,  4'hF};
    vecs[10] = '{1'b1, 1'b1, 4'd0,  4,  4'd0};

    rst_n_i     = 1'b0;
    req_valid_i = 1'b0;
    req_zero_i  = 1'b0;
    req_dir_i   = 1'b0;
    req_steps_i = '0;
    mmcm_rst_i  = 1'b0;
    locked_i    = 1'b1;
    err_clr_i   = 1'b0;

    repeat (3) @(negedge clk_i);
    checkOutput("rst_ps_en", 32'(ps_en_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_done", 32'(done_o), 0);
    checkOutput("rst_err", 32'(err_o), 0);
    checkOutput("rst_err_code", 32'(err_code_o), 0);
    checkOutput("rst_position", 32'(position_o), 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rst_ready", 32'(req_ready_o), 1);
    repeat (3) @(negedge clk_i);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].zero, vecs[i].dir, vecs[i].steps, vecs[i].k, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_position", i), 32'(position_o), 32'(vecs[i].exp_pos));
      checkOutput($sformatf("vec%0d_idle", i), 32'(busy_o), 0);
      checkOutput($sformatf("vec%0d_err", i), 32'(err_o), 0);
    end

    $display("[TB] PSDONE timeout sequence");
    @(negedge clk_i);
    model_respond = 1'b0;
    req_valid_i = 1'b1;
    req_zero_i  = 1'b0;
    req_dir_i   = 1'b1;
    req_steps_i = 4'd1;
    n = cyc;
    sb.push_back('{0, n + 1, 32'(1)});
    @(negedge clk_i);
    req_valid_i = 1'b0;
    waitCycle(n + 1 + TO);
    checkOutput("to_err_early", 32'(err_o), 0);
    waitCycle(n + 2 + TO);
    checkOutput("to_err", 32'(err_o), 1);
    checkOutput("to_err_code", 32'(err_code_o), 2);
    checkOutput("to_ready", 32'(req_ready_o), 0);
    checkOutput("to_busy", 32'(busy_o), 0);
    checkOutput("to_position", 32'(position_o), 0);
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    checkOutput("to_clr_err", 32'(err_o), 0);
    checkOutput("to_clr_code", 32'(err_code_o), 0);
    checkOutput("to_clr_ready", 32'(req_ready_o), 1);
    checkOutput("to_sb_empty", sb.size(), 0);
    sb.delete();
    model_respond = 1'b1;

    $display("[TB] lock loss sequence");
    @(negedge clk_i);
    model_k = 12;
    req_valid_i = 1'b1;
    req_zero_i  = 1'b0;
    req_dir_i   = 1'b1;
    req_steps_i = 4'd4;
    n  = cyc;
    t2 = n + 15;
    sb.push_back('{0, n + 1, 32'(1)});
    sb.push_back('{0, t2, 32'(1)});
    @(negedge clk_i);
    req_valid_i = 1'b0;
    waitCycle(t2 + 3);
    @(negedge clk_i);
    locked_i = 1'b0;
    waitCycle(t2 + 13);
    checkOutput("ll_err_early", 32'(err_o), 0);
    waitCycle(t2 + 14);
    checkOutput("ll_err", 32'(err_o), 1);
    checkOutput("ll_err_code", 32'(err_code_o), 1);
    checkOutput("ll_position", 32'(position_o), 2);
    checkOutput("ll_busy", 32'(busy_o), 0);
    checkOutput("ll_ready", 32'(req_ready_o), 0);
    waitCycle(t2 + 40);
    checkOutput("ll_sb_empty", sb.size(), 0);
    checkOutput("ll_position_hold", 32'(position_o), 2);
    sb.delete();

    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    checkOutput("ll_clr_err", 32'(err_o), 0);
    checkOutput("ll_clr_ready", 32'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_steps_i = 4'd1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("acc_unlocked_err", 32'(err_o), 1);
    checkOutput("acc_unlocked_code", 32'(err_code_o), 1);
    checkOutput("acc_unlocked_busy", 32'(busy_o), 0);
    repeat (4) @(negedge clk_i);
    checkOutput("acc_unlocked_position", 32'(position_o), 2);
    locked_i = 1'b1;
    repeat (4) @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    checkOutput("acc_unlocked_clr_ready", 32'(req_ready_o), 1);

    $display("[TB] mmcm reset abort sequence");
    @(negedge clk_i);
    model_respond = 1'b0;
    req_valid_i = 1'b1;
    req_dir_i   = 1'b0;
    req_steps_i = 4'd1;
    n = cyc;
    sb.push_back('{0, n + 1, 32'(0)});
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    mmcm_rst_i = 1'b1;
    #1;
    checkOutput("mr_ready_low", 32'(req_ready_o), 0);
    @(negedge clk_i);
    checkOutput("mr_ps_en", 32'(ps_en_o), 0);
    checkOutput("mr_position", 32'(position_o), 0);
    checkOutput("mr_busy", 32'(busy_o), 0);
    checkOutput("mr_err", 32'(err_o), 0);
    mmcm_rst_i = 1'b0;
    @(negedge clk_i);
    manual_done = 1'b1;
    @(negedge clk_i);
    manual_done = 1'b0;
    @(negedge clk_i);
    checkOutput("mr_late_done_position", 32'(position_o), 0);
    checkOutput("mr_late_done_busy", 32'(busy_o), 0);
    checkOutput("mr_ready", 32'(req_ready_o), 1);
    checkOutput("mr_sb_empty", sb.size(), 0);
    sb.delete();
    model_respond = 1'b1;
    model_pos = '0;

    applyStimulus(1'b0, 1'b0, 4'd1, 3, "post_mr");
    checkOutput("post_mr_position", 32'(position_o), 32'(4'hF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
